// File: rtl/led_pattern_sequencer.sv
// Step sequencer for the LED blinker: plays a 4-entry table of {en, s1, s2, duration}
// once or looping, owning the blinker enable and rate-select switches while running.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | outputs low, table writable, waiting for start
// LOAD   | one cycle: fetch entry[step], apply it or skip a zero duration
// RUN    | hold step outputs for dur x TICK_DIV cycles
// FINISH | one cycle: o_done pulse, outputs low, then back to IDLE

module led_pattern_sequencer #(
   parameter int TICK_DIV = 25000,
   parameter int DUR_W    = 10
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_loop,
   input  logic             i_cfg_we,
   input  logic [1:0]       i_cfg_addr,
   input  logic [DUR_W+2:0] i_cfg_data,
   output logic             o_enable,
   output logic             o_switch_1,
   output logic             o_switch_2,
   output logic             o_busy,
   output logic             o_done,
   output logic [1:0]       o_step,
   output logic             o_cfg_err
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_RUN    = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [DUR_W+2:0] r_table [4];
   logic [TW-1:0]    r_tick;
   logic [DUR_W-1:0] r_dur;
   logic [1:0]       r_step;
   logic             r_loop;
   logic             r_pass;
   logic             r_enable;
   logic             r_switch_1;
   logic             r_switch_2;
   logic             r_busy;
   logic             r_done;
   logic             r_cfg_err;

   logic [DUR_W+2:0] w_entry;
   logic [DUR_W-1:0] w_entry_dur;
   logic             w_tick_end;
   logic             w_dur_last;
   logic             w_start_ok;
   logic             w_step_load;
   logic             w_advance;
   logic             w_wrap;
   logic             w_outputs_off;

   assign w_entry     = r_table[r_step];
   assign w_entry_dur = w_entry[DUR_W-1:0];
   assign w_tick_end  = (r_tick == TICK_LAST);
   assign w_dur_last  = (r_dur == DUR_W'(1));

   always_comb begin
      w_next_state = r_state;
      w_start_ok   = 1'b0;
      w_step_load  = 1'b0;
      w_advance    = 1'b0;
      w_wrap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_stop) begin
               w_start_ok   = 1'b1;
               w_next_state = S_LOAD;
            end
         end
         S_LOAD: begin
            if (i_stop) begin
               w_next_state = S_IDLE;
            end else if (w_entry_dur != '0) begin
               w_step_load  = 1'b1;
               w_next_state = S_RUN;
            end else begin
               w_advance = 1'b1;
            end
         end
         S_RUN: begin
            if (i_stop) begin
               w_next_state = S_IDLE;
            end else if (w_tick_end && w_dur_last) begin
               w_advance = 1'b1;
            end
         end
         S_FINISH: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      // The pass flag stops an all-skip looping table from spinning forever.
      if (w_advance) begin
         if (r_step != 2'd3) begin
            w_next_state = S_LOAD;
         end else if (r_loop && r_pass) begin
            w_wrap       = 1'b1;
            w_next_state = S_LOAD;
         end else begin
            w_next_state = S_FINISH;
         end
      end
   end

   assign w_outputs_off = (w_next_state == S_IDLE) || (w_next_state == S_FINISH);

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         for (int i = 0; i < 4; i++) begin
            r_table[i] <= '0;
         end
         r_tick     <= '0;
         r_dur      <= '0;
         r_step     <= '0;
         r_loop     <= 1'b0;
         r_pass     <= 1'b0;
         r_enable   <= 1'b0;
         r_switch_1 <= 1'b0;
         r_switch_2 <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_busy    <= (w_next_state == S_LOAD) || (w_next_state == S_RUN);
         r_done    <= (w_next_state == S_FINISH);
         r_cfg_err <= i_cfg_we && (r_state != S_IDLE);

         if (i_cfg_we && (r_state == S_IDLE)) begin
            r_table[i_cfg_addr] <= i_cfg_data;
         end

         if (w_start_ok) begin
            r_loop <= i_loop;
            r_step <= 2'd0;
            r_pass <= 1'b0;
         end

         if (w_step_load) begin
            r_enable   <= w_entry[DUR_W+2];
            r_switch_1 <= w_entry[DUR_W+1];
            r_switch_2 <= w_entry[DUR_W];
            r_dur      <= w_entry_dur;
            r_tick     <= '0;
            r_pass     <= 1'b1;
         end else if (r_state == S_RUN) begin
            if (w_tick_end) begin
               r_tick <= '0;
               r_dur  <= r_dur - DUR_W'(1);
            end else begin
               r_tick <= r_tick + TW'(1);
            end
         end

         if (w_wrap) begin
            r_step <= 2'd0;
            r_pass <= 1'b0;
         end else if (w_advance && (r_step != 2'd3)) begin
            r_step <= r_step + 2'd1;
         end

         if (w_outputs_off) begin
            r_enable   <= 1'b0;
            r_switch_1 <= 1'b0;
            r_switch_2 <= 1'b0;
         end
      end
   end

   assign o_enable   = r_enable;
   assign o_switch_1 = r_switch_1;
   assign o_switch_2 = r_switch_2;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_step     = r_step;
   assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: each run is compared cycle by cycle
// against a trace built from the step table (LOAD cycle plus dur x TICK run cycles per step).

module tb_led_pattern_sequencer;

   localparam int TICK  = 4;
   localparam int DUR_W = 10;

   typedef struct packed {
      logic       busy;
      logic       en;
      logic       s1;
      logic       s2;
      logic [1:0] step;
      logic       done;
   } rec_t;

   logic             clk;
   logic             i_reset_n;
   logic             i_start;
   logic             i_stop;
   logic             i_loop;
   logic             i_cfg_we;
   logic [1:0]       i_cfg_addr;
   logic [DUR_W+2:0] i_cfg_data;
   logic             o_enable;
   logic             o_switch_1;
   logic             o_switch_2;
   logic             o_busy;
   logic             o_done;
   logic [1:0]       o_step;
   logic             o_cfg_err;

   int               n_tests;
   int               n_fail;
   logic [12:0]      tb_tbl [4];
   rec_t             exp_q [$];
   bit               exp_complete;

   led_pattern_sequencer #(.TICK_DIV(TICK), .DUR_W(DUR_W)) dut (
      .i_clock    (clk),
      .i_reset_n  (i_reset_n),
      .i_start    (i_start),
      .i_stop     (i_stop),
      .i_loop     (i_loop),
      .i_cfg_we   (i_cfg_we),
      .i_cfg_addr (i_cfg_addr),
      .i_cfg_data (i_cfg_data),
      .o_enable   (o_enable),
      .o_switch_1 (o_switch_1),
      .o_switch_2 (o_switch_2),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_step     (o_step),
      .o_cfg_err  (o_cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference trace: per step one LOAD cycle (previous outputs held), then dur*TICK cycles
   // showing the step's outputs; all-zero passes end the loop; FINISH then IDLE close the run.
   task automatic build_expected(input logic lp, input int max_len);
      rec_t     r;
      logic [2:0] cur;
      bit       any;
      int       d;
      exp_q.delete();
      exp_complete = 0;
      cur = 3'b000;
      any = 0;
      for (int i = 0; i < 4; i++) if (tb_tbl[i][9:0] != 0) any = 1;
      do begin
         for (int s = 0; s < 4; s++) begin
            d = int'(tb_tbl[s][9:0]);
            r = '{busy: 1'b1, en: cur[2], s1: cur[1], s2: cur[0], step: 2'(s), done: 1'b0};
            exp_q.push_back(r);
            if (d != 0) begin
               cur = tb_tbl[s][12:10];
               for (int c = 0; c < d * TICK; c++) begin
                  r = '{busy: 1'b1, en: cur[2], s1: cur[1], s2: cur[0], step: 2'(s), done: 1'b0};
                  exp_q.push_back(r);
               end
            end
            if (exp_q.size() >= max_len) return;
         end
      end while (lp && any);
      r = '{busy: 1'b0, en: 1'b0, s1: 1'b0, s2: 1'b0, step: 2'd3, done: 1'b1};
      exp_q.push_back(r);
      r.done = 1'b0;
      exp_q.push_back(r);
      exp_complete = 1;
   endtask

   task automatic write_entry(input logic [1:0] a, input logic [12:0] d);
      i_cfg_we   = 1'b1;
      i_cfg_addr = a;
      i_cfg_data = d;
      @(negedge clk);
      i_cfg_we = 1'b0;
      tb_tbl[a] = d;
      n_tests++;
      if (o_cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_write_err addr %0d: got %b required 0", a, o_cfg_err);
      end
   endtask

   task automatic load_directed();
      write_entry(2'd0, {3'b100, 10'd2});
      write_entry(2'd1, {3'b101, 10'd1});
      write_entry(2'd2, {3'b110, 10'd3});
      write_entry(2'd3, {3'b111, 10'd1});
   endtask

   // Starts a run and compares every cycle against exp_q; optional stop, write and
   // start injections at given trace indices.
   task automatic play(input string name, input logic lp, input int stop_at,
                       input int wr_at, input int st_at,
                       input logic [1:0] wr_addr, input logic [12:0] wr_data);
      rec_t got;
      logic exp_err;
      i_loop  = lp;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_loop  = ~lp;
      for (int k = 0; k < exp_q.size(); k++) begin
         got     = {o_busy, o_enable, o_switch_1, o_switch_2, o_step, o_done};
         exp_err = (wr_at >= 0) && (k == wr_at + 1);
         n_tests++;
         if ({got, o_cfg_err} !== {exp_q[k], exp_err}) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got busy,en,s1,s2,step,done,err=%b required %b",
                     name, k, {got, o_cfg_err}, {exp_q[k], exp_err});
         end
         i_start    = (k == st_at);
         i_stop     = (k == stop_at);
         i_cfg_we   = (k == wr_at);
         i_cfg_addr = wr_addr;
         i_cfg_data = wr_data;
         @(negedge clk);
         i_start  = 1'b0;
         i_stop   = 1'b0;
         i_cfg_we = 1'b0;
         if (k == stop_at) begin
            for (int j = 0; j < 3; j++) begin
               n_tests++;
               if ({o_busy, o_enable, o_switch_1, o_switch_2, o_done} !== 5'b0) begin
                  n_fail++;
                  $display("FAIL %s after_stop %0d: got busy,en,s1,s2,done=%b required 00000",
                           name, j, {o_busy, o_enable, o_switch_1, o_switch_2, o_done});
               end
               @(negedge clk);
            end
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({o_busy, o_enable, o_switch_1, o_switch_2, o_done, o_step, o_cfg_err} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 00000000",
                  {o_busy, o_enable, o_switch_1, o_switch_2, o_done, o_step, o_cfg_err});
      end
      load_directed();
      i_loop  = 1'b0;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (6) @(negedge clk);
      i_reset_n = 1'b0;
      @(negedge clk);
      i_reset_n = 1'b1;
      n_tests++;
      if ({o_busy, o_enable, o_switch_1, o_switch_2, o_done, o_step, o_cfg_err} !== 8'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: got %b required 00000000",
                  {o_busy, o_enable, o_switch_1, o_switch_2, o_done, o_step, o_cfg_err});
      end
      for (int i = 0; i < 4; i++) tb_tbl[i] = '0;
      build_expected(1'b0, 1000);
      play("cleared_table_once", 1'b0, -1, -1, -1, 2'd0, 13'd0);
      build_expected(1'b1, 1000);
      play("cleared_table_loop", 1'b1, -1, -1, -1, 2'd0, 13'd0);
   endtask

   task automatic test_table_once();
      load_directed();
      build_expected(1'b0, 1000);
      play("table_once", 1'b0, -1, -1, -1, 2'd0, 13'd0);
   endtask

   task automatic test_loop_stop();
      build_expected(1'b1, 60);
      play("loop_stop", 1'b1, 50, -1, -1, 2'd0, 13'd0);
   endtask

   task automatic test_skip();
      write_entry(2'd0, {3'b101, 10'd1});
      write_entry(2'd1, {3'b010, 10'd0});
      write_entry(2'd2, {3'b011, 10'd1});
      write_entry(2'd3, {3'b110, 10'd1});
      build_expected(1'b0, 1000);
      play("skip_step1", 1'b0, -1, -1, -1, 2'd0, 13'd0);
   endtask

   task automatic test_cfg_and_start_in_run();
      load_directed();
      build_expected(1'b0, 1000);
      play("cfg_write_in_run", 1'b0, -1, 11, 20, 2'd1, {3'b011, 10'd7});
      play("table_unchanged", 1'b0, -1, -1, -1, 2'd0, 13'd0);
      i_start = 1'b1;
      i_stop  = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_stop  = 1'b0;
      for (int j = 0; j < 2; j++) begin
         n_tests++;
         if ({o_busy, o_enable, o_done} !== 3'b0) begin
            n_fail++;
            $display("FAIL start_stop_idle %0d: got busy,en,done=%b required 000", j,
                     {o_busy, o_enable, o_done});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [12:0] d;
      logic        lp;
      int          stop_at;
      int          st_at;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 4; i++) begin
            d[12:10] = 3'($urandom_range(0, 7));
            d[9:0]   = 10'($urandom_range(0, 3));
            write_entry(2'(i), d);
         end
         lp = 1'($urandom_range(0, 1));
         build_expected(lp, 200);
         stop_at = -1;
         st_at   = -1;
         if (!exp_complete) stop_at = $urandom_range(0, exp_q.size() - 1);
         else st_at = $urandom_range(0, exp_q.size() - 3);
         play("random", lp, stop_at, -1, st_at, 2'd0, 13'd0);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      i_reset_n  = 1'b0;
      i_start    = 1'b0;
      i_stop     = 1'b0;
      i_loop     = 1'b0;
      i_cfg_we   = 1'b0;
      i_cfg_addr = 2'd0;
      i_cfg_data = '0;
      for (int i = 0; i < 4; i++) tb_tbl[i] = '0;
      repeat (3) @(negedge clk);
      i_reset_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_table_once();
      test_loop_stop();
      test_skip();
      test_cfg_and_start_in_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
